// File: rtl/fas_fft_frame_sched.sv
// FAS frame scheduler: packs FIR samples into ping-pong
// frames and hands each full frame to the 16-point FFT engine.
module fas_fft_frame_sched #(
    parameter int DW      = 16,
    parameter int NPT     = 16,
    parameter int NFRAMES = 64,
    localparam int AW     = $clog2(NPT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fir_valid,
    input  logic [DW-1:0] fir_d,
    output logic          eng_start,
    input  logic          eng_done,
    input  logic [AW-1:0] eng_rd_addr,
    output logic [DW-1:0] eng_rd_data,
    output logic          fft_valid,
    output logic [6:0]    frame_cnt,
    output logic          all_done,
    output logic          overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [6:0]    LAST_FRM = 7'(NFRAMES - 1);
    localparam logic [6:0]    MAX_FRM  = 7'(NFRAMES);
    localparam logic [AW-1:0] LAST_PTR = AW'(NPT - 1);

    logic [DW-1:0] mem [2][NPT];
    logic [1:0]    full;
    logic [1:0]    full_nx;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_ptr;
    state_t        state;
    state_t        state_nx;
    logic          done_acc;
    logic          free_wr;
    logic          wr_ok;
    logic          wr_en;
    logic          drop;
    logic          wr_last;

    // A bank freed by the engine this cycle may be refilled at once.
    assign free_wr = done_acc && (rd_bank == wr_bank);
    assign wr_ok   = !full[wr_bank] || free_wr;
    assign wr_en   = fir_valid && !all_done && wr_ok;
    assign drop    = fir_valid && !all_done && !wr_ok;
    assign wr_last = (wr_ptr == LAST_PTR);

    assign eng_rd_data = mem[rd_bank][eng_rd_addr];

    // Frame buffer storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_ptr] <= fir_d;
        end
    end

    // Bank occupancy: the engine free lands before a new fill mark.
    always_comb begin
        full_nx = full;
        if (done_acc) begin
            full_nx[rd_bank] = 1'b0;
        end
        if (wr_en && wr_last) begin
            full_nx[wr_bank] = 1'b1;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and engine handshake decode.
    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        all_done  = 1'b0;
        done_acc  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                eng_start = 1'b1;
                state_nx  = S_RUN;
            end
            S_RUN: begin
                if (eng_done) begin
                    done_acc = 1'b1;
                    if (frame_cnt == LAST_FRM) begin
                        state_nx = S_FIN;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_FIN: begin
                all_done = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Write pointer, bank flags, frame counting and loss flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_ptr    <= '0;
            fft_valid <= 1'b0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            full      <= full_nx;
            fft_valid <= done_acc;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (drop) begin
                overrun <= 1'b1;
            end
            if (done_acc) begin
                rd_bank <= ~rd_bank;
                if (frame_cnt != MAX_FRM) begin
                    frame_cnt <= frame_cnt + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fas_fft_frame_sched.sv
// Randomized scoreboard bench for the FAS frame scheduler,
// with the bench acting as the FFT engine.
module tb_fas_fft_frame_sched;

    localparam int DW  = 16;
    localparam int NPT = 16;
    localparam int NF  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fir_valid = 1'b0;
    logic [DW-1:0] fir_d = '0;
    logic          eng_done = 1'b0;
    logic [3:0]    eng_rd_addr = '0;
    logic          eng_start;
    logic [DW-1:0] eng_rd_data;
    logic          fft_valid;
    logic [6:0]    frame_cnt;
    logic          all_done;
    logic          overrun;

    fas_fft_frame_sched #(
        .DW(DW),
        .NPT(NPT),
        .NFRAMES(NF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fir_valid(fir_valid),
        .fir_d(fir_d),
        .eng_start(eng_start),
        .eng_done(eng_done),
        .eng_rd_addr(eng_rd_addr),
        .eng_rd_data(eng_rd_data),
        .fft_valid(fft_valid),
        .frame_cnt(frame_cnt),
        .all_done(all_done),
        .overrun(overrun)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic       fv;
        logic       ov;
        logic       ad;
        logic [6:0] cnt;
    } exp_t;

    exp_t               exp_q[$];
    logic [NPT*DW-1:0]  frm_q[$];

    // reference model: frames as plain sample lists plus a bank count
    logic [NPT*DW-1:0]  part;
    int                 pn = 0;
    int                 pend = 0;
    int                 m_cnt = 0;
    bit                 m_ov = 1'b0;
    bit                 busy = 1'b0;
    int                 timer = 0;
    int                 lat_lo = 20;
    int                 lat_hi = 20;
    int                 cyc = 0;
    int                 start_cyc = -100;
    int                 wr_cyc = 0;
    int                 fv_seen = 0;
    int                 n_pass = 0;
    int                 n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            $display("FAIL %s got %h exp %h (cyc %0d)", nm, got, want, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit r,
                        input bit v_on_done, input bit spur);
        bit done;
        bit freed;
        bit adone;
        @(negedge clk);
        cyc++;
        done = spur;
        if (eng_start) begin
            chk("start_while_busy", 32'(busy), 0);
            busy      = 1'b1;
            timer     = int'($urandom_range(lat_hi, lat_lo));
            start_cyc = cyc;
        end else if (busy) begin
            timer--;
            if (timer <= 0) begin
                done = 1'b1;
            end
        end
        if (v_on_done && done) begin
            v = 1'b1;
        end
        rst       = !r;
        fir_valid = v;
        fir_d     = d;
        eng_done  = done;
        if (r) begin
            pn    = 0;
            pend  = 0;
            m_cnt = 0;
            m_ov  = 1'b0;
            busy  = 1'b0;
            frm_q.delete();
            exp_q.push_back('0);
        end else begin
            freed = done && busy;
            if (freed) begin
                busy = 1'b0;
            end
            adone = (m_cnt == NF);
            if (v && !adone) begin
                if (pend < 2 || freed) begin
                    part[pn*DW +: DW] = d;
                    pn++;
                end else begin
                    m_ov = 1'b1;
                end
            end
            if (freed) begin
                pend--;
                if (m_cnt < NF) m_cnt++;
            end
            if (pn == NPT) begin
                pend++;
                frm_q.push_back(part);
                pn = 0;
            end
            exp_q.push_back({freed, m_ov, (m_cnt == NF), 7'(m_cnt)});
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic smp(input logic [DW-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((pend > 0 || busy || frm_q.size() > 0) && k < 800) begin
            idle();
            k++;
        end
        chk("drain_bound", 32'(k < 800), 1);
    endtask

    // Monitor: per-cycle status and per-frame engine read-back.
    exp_t              e;
    logic [NPT*DW-1:0] f;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fft_valid", 32'(fft_valid), 32'(e.fv));
            chk("overrun", 32'(overrun), 32'(e.ov));
            chk("all_done", 32'(all_done), 32'(e.ad));
            chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
            if (fft_valid) fv_seen++;
        end
        if (eng_start) begin
            if (frm_q.size() == 0) begin
                chk("unexpected_start", 32'(eng_start), 0);
            end else begin
                f = frm_q.pop_front();
                for (int a = 0; a < NPT; a++) begin
                    eng_rd_addr = 4'(a);
                    #1;
                    chk("rd_data", 32'(eng_rd_data), 32'(f[a*DW +: DW]));
                end
            end
        end
    end

    initial begin
        bit v;
        int sent;
        int guard;

        // T1: reset in the middle of a frame
        do_reset(2);
        for (int i = 0; i < 7; i++) smp(16'($urandom));
        do_reset(2);
        settle();
        chk("t1_eng_start", 32'(eng_start), 0);
        chk("t1_fft_valid", 32'(fft_valid), 0);
        chk("t1_frame_cnt", 32'(frame_cnt), 0);
        chk("t1_all_done", 32'(all_done), 0);
        chk("t1_overrun", 32'(overrun), 0);
        start_cyc = -100;
        for (int i = 0; i < NPT; i++) smp(16'($urandom));
        wr_cyc = cyc;
        repeat (3) idle();
        chk("t1_start_lat", 32'(start_cyc - wr_cyc), 2);
        drain();

        // T2: known ramp 1..16
        do_reset(1);
        start_cyc = -100;
        for (int i = 1; i <= NPT; i++) smp(16'(i));
        wr_cyc = cyc;
        repeat (3) idle();
        chk("t2_start_lat", 32'(start_cyc - wr_cyc), 2);
        drain();

        // T3: slow engine against a continuous stream
        do_reset(1);
        lat_lo = 40;
        lat_hi = 40;
        for (int i = 0; i < 40; i++) smp(16'($urandom));
        settle();
        chk("t3_overrun_set", 32'(overrun), 1);
        for (int i = 0; i < 60; i++) smp(16'($urandom));
        drain();
        settle();
        chk("t3_overrun_held", 32'(overrun), 1);

        // T4: sample arrives on the same cycle a bank is freed
        do_reset(1);
        lat_lo = 30;
        lat_hi = 30;
        for (int i = 0; i < 2 * NPT; i++) smp(16'($urandom));
        repeat (40) step(1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t4_no_overrun", 32'(overrun), 0);
        drain();

        // T6: eng_done while idle is ignored
        do_reset(1);
        lat_lo = 5;
        lat_hi = 5;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        settle();
        chk("t6_frame_cnt", 32'(frame_cnt), 0);
        chk("t6_fft_valid", 32'(fft_valid), 0);
        for (int i = 0; i < NPT; i++) smp(16'($urandom));
        drain();

        // T5: full run of NF frames
        do_reset(1);
        lat_lo = 10;
        lat_hi = 10;
        fv_seen = 0;
        sent = 0;
        guard = 0;
        while (sent < NF * NPT && guard < 5000) begin
            v = ($urandom_range(3, 0) != 0);
            step(v, 16'($urandom), 1'b0, 1'b0, 1'b0);
            if (v) sent++;
            guard++;
        end
        drain();
        settle();
        chk("t5_pulses", 32'(fv_seen), NF);
        chk("t5_frame_cnt", 32'(frame_cnt), NF);
        chk("t5_all_done", 32'(all_done), 1);
        chk("t5_overrun", 32'(overrun), 0);
        for (int i = 0; i < 20; i++) smp(16'($urandom));
        idle();
        settle();
        chk("t5_done_held", 32'(all_done), 1);
        chk("t5_cnt_held", 32'(frame_cnt), NF);
        chk("t5_no_overrun", 32'(overrun), 0);

        // T7: random traffic and random engine latency
        do_reset(1);
        lat_lo = 1;
        lat_hi = 45;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(9, 0) < 7);
            step(v, 16'($urandom), 1'b0, 1'b0, 1'b0);
        end
        drain();
        settle();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
